// File: rtl/inst_queue_if.sv
// Fetch/decode-side bundle for the instruction queue.
// The master modport belongs to the fetch/decode pair; the slave modport belongs to the queue.
interface inst_queue_if #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                flush;
  logic [1:0]          in_valid;
  logic [2*INST_W-1:0] in_inst;
  logic [PC_W-1:0]     in_pc;
  logic                in_ready;
  logic [1:0]          issue_en;
  logic [1:0]          out_valid;
  logic [2*INST_W-1:0] out_inst;
  logic [2*PC_W-1:0]   out_pc;
  logic [CW-1:0]       count;

  modport master (
    output flush, in_valid, in_inst, in_pc, issue_en,
    input  in_ready, out_valid, out_inst, out_pc, count
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, issue_en,
    output in_ready, out_valid, out_inst, out_pc, count
  );
endinterface

// File: rtl/inst_queue.sv
// Dual-ported instruction queue: the fetch side pushes up to two instructions per cycle,
// and the decode side sees the two oldest entries and retires up to two per cycle.
module inst_queue #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  inst_queue_if.slave  q_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INST_W-1:0] r_mem_inst [DEPTH];
  logic [PC_W-1:0]   r_mem_pc   [DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic              w_in_ready;
  logic [1:0]        w_push_n;
  logic [1:0]        w_pop_req;
  logic [1:0]        w_pop_n;
  logic              w_wr_a;
  logic              w_wr_b;
  logic [INST_W-1:0] w_inst_a;
  logic [INST_W-1:0] w_inst_b;
  logic [PC_W-1:0]   w_pc_a;
  logic [PC_W-1:0]   w_pc_b;
  logic [AW-1:0]     w_rd_ptr1;
  logic [AW-1:0]     w_wr_ptr1;
  logic [CW:0]       w_count_sum;
  logic [CW:0]       w_count_next;

  assign w_in_ready = (r_count <= CW'(DEPTH - 2));
  assign w_rd_ptr1  = r_rd_ptr + AW'(1);
  assign w_wr_ptr1  = r_wr_ptr + AW'(1);

  assign w_push_n = (w_in_ready && !q_if.flush)
                  ? ({1'b0, q_if.in_valid[0]} + {1'b0, q_if.in_valid[1]}) : 2'd0;

  always_comb begin
    w_pop_req = 2'd0;
    case (q_if.issue_en)
      2'b01:   w_pop_req = 2'd1;
      2'b11:   w_pop_req = 2'd2;
      default: w_pop_req = 2'd0;
    endcase
    // Never pop more than is held, so decode may over-request safely
    w_pop_n = (CW'(w_pop_req) > r_count) ? r_count[1:0] : w_pop_req;
    if (q_if.flush) w_pop_n = 2'd0;
  end

  always_comb begin
    w_wr_a   = (w_push_n != 2'd0);
    w_wr_b   = (w_push_n == 2'd2);
    w_inst_b = q_if.in_inst[2*INST_W-1:INST_W];
    w_pc_b   = q_if.in_pc + PC_W'(4);
    w_inst_a = q_if.in_inst[INST_W-1:0];
    w_pc_a   = q_if.in_pc;
    // A lone slot1 instruction is packed into the first free entry
    if (q_if.in_valid == 2'b10) begin
      w_inst_a = w_inst_b;
      w_pc_a   = w_pc_b;
    end
  end

  assign w_count_sum  = {1'b0, r_count} + (CW+1)'(w_push_n);
  assign w_count_next = w_count_sum - (CW+1)'(w_pop_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (q_if.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(w_pop_n);
      r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
      r_count  <= w_count_next[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_a) begin
      r_mem_inst[r_wr_ptr] <= w_inst_a;
      r_mem_pc[r_wr_ptr]   <= w_pc_a;
    end
    if (w_wr_b) begin
      r_mem_inst[w_wr_ptr1] <= w_inst_b;
      r_mem_pc[w_wr_ptr1]   <= w_pc_b;
    end
  end

  assign q_if.in_ready  = w_in_ready;
  assign q_if.count     = r_count;
  assign q_if.out_valid = {(r_count >= CW'(2)), (r_count >= CW'(1))};
  assign q_if.out_inst  = {r_mem_inst[w_rd_ptr1], r_mem_inst[r_rd_ptr]};
  assign q_if.out_pc    = {r_mem_pc[w_rd_ptr1], r_mem_pc[r_rd_ptr]};

  always @(posedge clk) begin
    if (rst && !q_if.flush) begin
      assert (q_if.issue_en != 2'b10)
        else $error("inst_queue: illegal issue_en=10");
      assert (w_count_sum >= (CW+1)'(w_pop_n))
        else $error("inst_queue: count underflow");
      assert (w_count_next <= (CW+1)'(DEPTH))
        else $error("inst_queue: count overflow");
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue, with expected values worked out by hand.
module tb_inst_queue;
  localparam int DEPTH  = 16;
  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  inst_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) q_if ();

  inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .q_if (q_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic idle();
    q_if.flush    = 1'b0;
    q_if.in_valid = 2'b00;
    q_if.in_inst  = '0;
    q_if.in_pc    = '0;
    q_if.issue_en = 2'b00;
  endtask

  // Drive one cycle of stimulus, then return 1 time unit after the edge with inputs idle
  task automatic cyc(input logic fl, input logic [1:0] v, input logic [31:0] i1,
                     input logic [31:0] i0, input logic [63:0] pc, input logic [1:0] iss);
    q_if.flush    = fl;
    q_if.in_valid = v;
    q_if.in_inst  = {i1, i0};
    q_if.in_pc    = pc;
    q_if.issue_en = iss;
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    int idx;
    int cnt;
    idle();
    #12;
    chk("rst_count", 128'(q_if.count), 128'd0);
    chk("rst_valid", 128'(q_if.out_valid), 128'd0);
    chk("rst_ready", 128'(q_if.in_ready), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_count", 128'(q_if.count), 128'd0);
    chk("idle_valid", 128'(q_if.out_valid), 128'd0);

    // Double push into an empty queue
    cyc(0, 2'b11, 32'h0020_0093, 32'h0010_0093, 64'h8000_0000, 2'b00);
    chk("dbl_valid", 128'(q_if.out_valid), 128'd3);
    chk("dbl_pc", 128'(q_if.out_pc), {64'h8000_0004, 64'h8000_0000});
    chk("dbl_inst", 128'(q_if.out_inst), 128'({32'h0020_0093, 32'h0010_0093}));
    chk("dbl_count", 128'(q_if.count), 128'd2);
    cyc(0, 2'b00, 0, 0, 0, 2'b11);
    chk("pop2_count", 128'(q_if.count), 128'd0);
    chk("pop2_valid", 128'(q_if.out_valid), 128'd0);

    // Lone slot1 push takes pc+4; over-requested pop is clipped
    cyc(0, 2'b10, 32'hAAAA_0001, 32'hBBBB_0000, 64'h1000, 2'b00);
    chk("s1_count", 128'(q_if.count), 128'd1);
    chk("s1_valid", 128'(q_if.out_valid), 128'd1);
    chk("s1_pc", 128'(q_if.out_pc[63:0]), 128'h1004);
    chk("s1_inst", 128'(q_if.out_inst[31:0]), 128'hAAAA_0001);
    cyc(0, 2'b00, 0, 0, 0, 2'b11);
    chk("clip_count", 128'(q_if.count), 128'd0);

    // Fill to full; entry j holds inst 0x10000000+j, pc 0x2000+4j
    for (int k = 0; k < 7; k++)
      cyc(0, 2'b11, 32'h1000_0000 + 32'(2*k+1), 32'h1000_0000 + 32'(2*k), 64'h2000 + 64'(8*k), 2'b00);
    chk("fill14_count", 128'(q_if.count), 128'd14);
    chk("fill14_ready", 128'(q_if.in_ready), 128'd1);
    cyc(0, 2'b11, 32'h1000_000F, 32'h1000_000E, 64'h2038, 2'b00);
    chk("full_count", 128'(q_if.count), 128'd16);
    chk("full_ready", 128'(q_if.in_ready), 128'd0);
    cyc(0, 2'b11, 32'hDEAD_0001, 32'hDEAD_0000, 64'h9000, 2'b00);
    chk("ovf_count", 128'(q_if.count), 128'd16);
    chk("ovf_inst", 128'(q_if.out_inst), 128'({32'h1000_0001, 32'h1000_0000}));
    chk("ovf_pc", 128'(q_if.out_pc), {64'h2004, 64'h2000});
    cyc(0, 2'b00, 0, 0, 0, 2'b01);
    chk("c15_count", 128'(q_if.count), 128'd15);
    chk("c15_ready", 128'(q_if.in_ready), 128'd0);
    cyc(0, 2'b01, 32'h0, 32'hDEAD_0002, 64'h9100, 2'b00);
    chk("c15_push_ign", 128'(q_if.count), 128'd15);

    // Drain two at a time, checking FIFO order; the final request is clipped to 1
    idx = 1;
    cnt = 15;
    for (int n = 0; n < 8; n++) begin
      chk("drain_inst0", 128'(q_if.out_inst[31:0]), 128'(32'h1000_0000 + 32'(idx)));
      if (cnt >= 2)
        chk("drain_inst1", 128'(q_if.out_inst[63:32]), 128'(32'h1000_0000 + 32'(idx + 1)));
      cyc(0, 2'b00, 0, 0, 0, 2'b11);
      idx += (cnt >= 2) ? 2 : 1;
      cnt -= (cnt >= 2) ? 2 : 1;
      chk("drain_count", 128'(q_if.count), 128'(cnt));
    end

    // Asynchronous reset mid-operation
    cyc(0, 2'b11, 32'h2, 32'h1, 64'h100, 2'b00);
    cyc(0, 2'b11, 32'h4, 32'h3, 64'h108, 2'b00);
    cyc(0, 2'b01, 32'h0, 32'h5, 64'h110, 2'b00);
    chk("pre_rst_count", 128'(q_if.count), 128'd5);
    #2 rst = 1'b0;
    #1;
    chk("arst_count", 128'(q_if.count), 128'd0);
    chk("arst_valid", 128'(q_if.out_valid), 128'd0);
    chk("arst_ready", 128'(q_if.in_ready), 128'd1);
    #2 rst = 1'b1;

    // Move both pointers to 14
    for (int k = 0; k < 7; k++)
      cyc(0, 2'b11, 32'h0, 32'h0, 64'h0, 2'b00);
    for (int k = 0; k < 7; k++)
      cyc(0, 2'b00, 0, 0, 0, 2'b11);
    chk("wrap_empty", 128'(q_if.count), 128'd0);
    cyc(0, 2'b01, 32'h0, 32'hA0A0_0000, 64'h3000, 2'b00);
    cyc(0, 2'b11, 32'hC0C0_0000, 32'hB0B0_0000, 64'h3004, 2'b00);
    chk("wrap_count3", 128'(q_if.count), 128'd3);
    chk("wrap_inst_ab", 128'(q_if.out_inst), 128'({32'hB0B0_0000, 32'hA0A0_0000}));
    cyc(0, 2'b11, 32'hE0E0_0000, 32'hD0D0_0000, 64'h300C, 2'b11);
    chk("wrap_pp_count", 128'(q_if.count), 128'd3);
    chk("wrap_inst_cd", 128'(q_if.out_inst), 128'({32'hD0D0_0000, 32'hC0C0_0000}));
    chk("wrap_pc_cd", 128'(q_if.out_pc), {64'h300C, 64'h3008});
    cyc(0, 2'b00, 0, 0, 0, 2'b01);
    chk("wrap_inst_de", 128'(q_if.out_inst), 128'({32'hE0E0_0000, 32'hD0D0_0000}));

    // Flush has priority over a simultaneous push and pop
    cyc(0, 2'b11, 32'h2, 32'h1, 64'h400, 2'b00);
    cyc(0, 2'b11, 32'h4, 32'h3, 64'h408, 2'b00);
    chk("pre_flush_count", 128'(q_if.count), 128'd6);
    cyc(1, 2'b11, 32'h6, 32'h5, 64'h410, 2'b11);
    chk("flush_count", 128'(q_if.count), 128'd0);
    chk("flush_valid", 128'(q_if.out_valid), 128'd0);
    cyc(0, 2'b11, 32'h0000_0F02, 32'h0000_0F01, 64'h5000, 2'b00);
    chk("post_flush_count", 128'(q_if.count), 128'd2);
    chk("post_flush_inst", 128'(q_if.out_inst), 128'({32'h0000_0F02, 32'h0000_0F01}));
    chk("post_flush_pc", 128'(q_if.out_pc), {64'h5004, 64'h5000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
Dual-ported instruction queue between the instruction-bus fetch interface and the decode/issue stage of the dual-issue RV64 core.
- Accepts up to two fetched 32-bit instructions per cycle.
- Presents the two oldest entries, each tagged with its PC, to decode.
- Retires 0, 1 or 2 entries per cycle according to the issue-enable vector from decode.
- A flush discards all queued instructions on redirect.

Parameters:
DEPTH, 16, number of entries; power of two, at least 4
PC_W, 64, PC width
INST_W, 32, instruction width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous reset, active-low (state cleared while rst==0)
flush  input  1  discard all entries, synchronous
in_valid  input  2  bit0 = slot0 inst valid, bit1 = slot1 inst valid
in_inst  input  2*INST_W  slot0 at [INST_W-1:0], slot1 above it
in_pc  input  PC_W  PC of slot0; slot1 PC = in_pc+4
in_ready  output  1  at least 2 free entries; fetch may push
issue_en  input  2  pop request from decode
out_valid  output  2  bit i = out entry i holds a valid instruction
out_inst  output  2*INST_W  oldest entry in low half, next-oldest in high half
out_pc  output  2*PC_W  PCs matching out_inst
count  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Storage: circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. count is held in a separate register.
- Reset (rst==0, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0.
  - out_valid=2'b00 and in_ready=1.
  - Storage contents are don't-care.
- Outputs (combinational from state, no bypass):
  - out_valid[0] = (count>=1); out_valid[1] = (count>=2).
  - Out entry 0 = mem[rd_ptr]; out entry 1 = mem[rd_ptr+1 mod DEPTH].
  - When out_valid[i]=0, out_inst and out_pc for that entry are don't-care.
- in_ready = (DEPTH - count >= 2).
- Push (only when in_ready=1 and flush=0):
  - Accepted instructions are packed contiguously, slot0 first.
  - in_valid=01: writes {in_inst[0], in_pc}.
  - in_valid=10: writes {in_inst[1], in_pc+4} to a single entry.
  - in_valid=11: writes slot0 at wr_ptr and slot1 at wr_ptr+1.
  - in_valid=00: no write.
  - push_n = popcount(in_valid). wr_ptr advances by push_n.
  - When in_ready=0, the push is ignored entirely. Fetch must hold its data; the queue never writes when it has fewer than 2 free entries.
- Pop:
  - issue_en=01 pops 1 entry; issue_en=11 pops 2.
  - issue_en=10 is illegal: treated as no pop, with a simulation assertion.
  - Requested pops are clipped to count: pop_n = min(requested, count).
  - rd_ptr advances by pop_n.
- Simultaneous push and pop in the same cycle:
  - count_next = count + push_n - pop_n.
  - in_ready is evaluated on the current count, before the pop.
  - Data pushed this cycle is visible on the outputs from the next cycle, so pushing into an empty queue takes 1 cycle to appear.
- Flush:
  - Next cycle: rd_ptr=wr_ptr=0, count=0, out_valid=00.
  - Flush has priority: push and pop in the flush cycle are discarded.
- Wrap-around: pointer addition is modulo DEPTH. An entry pair straddling DEPTH-1/0 is read and written correctly.
- count never exceeds DEPTH and never goes below 0. Include assertions for both.

Test Plan:
- Reset then idle -> out_valid=00, count=0, in_ready=1. Assert rst=0 mid-operation with count=5 -> count=0 and out_valid=00 immediately, without waiting for a clock edge.
- Push in_valid=11, in_inst={0x00200093,0x00100093}, in_pc=0x80000000; next cycle -> out_valid=11, out_pc={0x80000004,0x80000000}, count=2.
- Push in_valid=10, in_pc=0x1000, into an empty queue -> one entry, out_pc[0]=0x1004, count=1. Then issue_en=11 -> pops only 1, count=0.
- Fill a DEPTH=16 queue with 7 double pushes -> count=14, in_ready=1. One more double push -> count=16, in_ready=0. A further push is ignored: count stays 16 and data is unchanged.
- With count=3 and rd_ptr=14, push 11 and issue_en=11 in the same cycle -> count=3, rd_ptr=0. Outputs show the third-oldest and fourth-oldest entries in order across the wrap.
- count=6, flush=1 together with push 11 and issue_en=11 -> next cycle count=0, out_valid=00. The following push of 11 appears at out entries 0 and 1.
